// File: rtl/vec_mac_seq_ctrl.sv
// Job sequencer for the NUM_MACS-lane vector MAC: issues operand beats to the adder trees,
// tracks tree latency and accumulates lane sums into one result per job. Optional: VMAC_SEQ_CTRL_OVF_EN.
module vec_mac_seq_ctrl #(
    parameter int WIDTH    = 16,
    parameter int N        = 8,
    parameter int NUM_MACS = 2,
    parameter int LEN_W    = 8,
    parameter int TREE_LAT = 1,
    parameter int ACC_W    = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_MACS*N*WIDTH-1:0] in_a,
    input  logic [NUM_MACS*N*WIDTH-1:0] in_b,
    output logic [NUM_MACS*N*WIDTH-1:0] tree_a,
    output logic [NUM_MACS*N*WIDTH-1:0] tree_b,
    output logic                        tree_en,
    input  logic [NUM_MACS*2*WIDTH-1:0] tree_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_result,
    output logic                        out_ovf,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [LEN_W-1:0]              r_len;
    logic [LEN_W-1:0]              r_iss_cnt;
    logic [LEN_W-1:0]              r_ret_cnt;
    logic [ACC_W-1:0]              r_acc;
    logic [NUM_MACS*N*WIDTH-1:0]   r_tree_a;
    logic [NUM_MACS*N*WIDTH-1:0]   r_tree_b;
    logic                          r_tree_en;
    logic                          w_cfg_fire;
    logic                          w_in_fire;
    logic                          w_sum_valid;
    logic [LEN_W-1:0]              w_iss_inc;
    logic [LEN_W-1:0]              w_ret_inc;
    logic [ACC_W-1:0]              w_lane_ext [NUM_MACS];
    logic [ACC_W-1:0]              w_beat_sum;
    logic [ACC_W-1:0]              w_acc_nxt;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    assign w_cfg_fire = (r_state == IDLE) && cfg_valid;
    assign w_in_fire  = (r_state == RUN) && in_valid;
    assign w_iss_inc  = r_iss_cnt + LEN_ONE;
    assign w_ret_inc  = r_ret_cnt + LEN_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) w_state_nxt = (cfg_len == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (w_in_fire && (w_iss_inc == r_len)) w_state_nxt = DRAIN;
            end
            // The final return is checked as it arrives so the result is ready the next cycle.
            DRAIN: begin
                if (w_sum_valid && (w_ret_inc == r_len)) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_tree_a  <= '0;
            r_tree_b  <= '0;
            r_tree_en <= 1'b0;
        end else begin
            r_tree_en <= w_in_fire;
            if (w_in_fire) begin
                r_tree_a <= in_a;
                r_tree_b <= in_b;
            end
            if (w_cfg_fire) begin
                r_len     <= cfg_len;
                r_iss_cnt <= '0;
                r_ret_cnt <= '0;
            end else begin
                if (w_in_fire)   r_iss_cnt <= w_iss_inc;
                if (w_sum_valid) r_ret_cnt <= w_ret_inc;
            end
        end
    end

    generate
        if (TREE_LAT == 0) begin : g_no_dly
            assign w_sum_valid = r_tree_en;
        end else begin : g_dly
            logic [TREE_LAT-1:0] r_dly;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= r_tree_en;
                    for (int i = 1; i < TREE_LAT; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_sum_valid = r_dly[TREE_LAT-1];
        end
    endgenerate

    for (genvar g = 0; g < NUM_MACS; g++) begin : g_lane
        assign w_lane_ext[g] = ACC_W'($signed(tree_sum[g*2*WIDTH +: 2*WIDTH]));
    end

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < NUM_MACS; i++) w_beat_sum = w_beat_sum + w_lane_ext[i];
    end

    assign w_acc_nxt = r_acc + w_beat_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_acc <= '0;
        else if (w_cfg_fire)  r_acc <= '0;
        else if (w_sum_valid) r_acc <= w_acc_nxt;
    end

`ifdef VMAC_SEQ_CTRL_OVF_EN
    logic r_ovf;
    logic w_ovf_step;

    // Signed overflow: both addends share a sign that the wrapped sum does not.
    assign w_ovf_step = (r_acc[ACC_W-1] == w_beat_sum[ACC_W-1]) &&
                        (w_acc_nxt[ACC_W-1] != r_acc[ACC_W-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           r_ovf <= 1'b0;
        else if (w_cfg_fire)                r_ovf <= 1'b0;
        else if (w_sum_valid && w_ovf_step) r_ovf <= 1'b1;
    end

    assign out_ovf = r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

    assign tree_a     = r_tree_a;
    assign tree_b     = r_tree_b;
    assign tree_en    = r_tree_en;
    assign out_result = r_acc;

endmodule

// File: tb/tb_vec_mac_seq_ctrl.sv
// Directed bench for vec_mac_seq_ctrl with a one-cycle registered adder-tree model.
module tb_vec_mac_seq_ctrl;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int M  = 2;
    localparam int LW = 8;
    localparam int BW = M * N * W;
    localparam int SW = M * 2 * W;
`ifdef VMAC_SEQ_CTRL_OVF_EN
    localparam int ACC = 32;
`else
    localparam int ACC = 48;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [LW-1:0]   cfg_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BW-1:0]   in_a = '0;
    logic [BW-1:0]   in_b = '0;
    logic [BW-1:0]   tree_a;
    logic [BW-1:0]   tree_b;
    logic            tree_en;
    logic [SW-1:0]   tree_sum = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ACC-1:0]  out_result;
    logic            out_ovf;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int k;
    int en_cnt;
    logic seen;

    vec_mac_seq_ctrl #(
        .WIDTH(W), .N(N), .NUM_MACS(M), .LEN_W(LW), .TREE_LAT(1), .ACC_W(ACC)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .tree_a(tree_a), .tree_b(tree_b), .tree_en(tree_en), .tree_sum(tree_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [2*W-1:0] s, pa, pb;
        logic [SW-1:0] r;
        r = '0;
        for (int l = 0; l < M; l++) begin
            s = '0;
            for (int e = 0; e < N; e++) begin
                pa = {{W{a[(l*N+e)*W+W-1]}}, a[(l*N+e)*W +: W]};
                pb = {{W{b[(l*N+e)*W+W-1]}}, b[(l*N+e)*W +: W]};
                s  = s + pa * pb;
            end
            r[l*2*W +: 2*W] = s;
        end
        return r;
    endfunction

    // Adder trees with one cycle of latency.
    always @(posedge clk) tree_sum <= dot(tree_a, tree_b);

    function automatic logic [BW-1:0] fill(input logic [W-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < M * N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [ACC-1:0] obs, input logic [ACC-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [LW-1:0] len);
        cfg_valid = 1'b1;
        cfg_len   = len;
        tick();
        cfg_valid = 1'b0;
    endtask

    // k counts cycles since the last accept edge; the sample after that edge is cycle 1.
    task automatic wait_out(input string tag);
        while (!out_valid && k < 40) begin
            tick();
            k++;
            if (tree_en) en_cnt++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset held, then released
        tick(); tick(); tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tree_en", tree_en, 0);
        chk("rst_tree_a", |tree_a, 0);
        chk("rst_result", out_result, 0);
        chk("rst_ovf", out_ovf, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("nojob_in_ready", in_ready, 0);
        chk("nojob_busy", busy, 0);
        in_valid = 1'b0;

        // len=1, a=1, b=2: 2 lanes x 8 x 2 = 32, out_valid 3 cycles after accept
        in_a = fill(16'd1);
        in_b = fill(16'd2);
        send_cfg(8'd1);
        chk("t2_in_ready", in_ready, 1);
        chk("t2_cfg_ready", cfg_ready, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_tree_en", tree_en, 1);
        chk("t2_tree_a", tree_a[W-1:0], 1);
        chk("t2_in_ready_drop", in_ready, 0);
        k = 1;
        en_cnt = 0;
        wait_out("t2");
        chk("t2_latency", k, 3);
        chk("t2_result", out_result, 32);
        chk("t2_ovf", out_ovf, 0);
        chk("t2_busy", busy, 1);
        ack();
        chk("t2_ack_valid", out_valid, 0);
        chk("t2_ack_cfg_ready", cfg_ready, 1);

        // len=3, a=-3, b=5, in_valid 1,0,1,0,1: -240 per beat
        in_a = fill(16'hFFFD);
        in_b = fill(16'd5);
        send_cfg(8'd3);
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            if (tree_en) en_cnt++;
        end
        in_valid = 1'b0;
        chk("t3_in_ready_drop", in_ready, 0);
        k = 1;
        wait_out("t3");
        chk("t3_en_pulses", en_cnt, 3);
        chk("t3_result", out_result, -720);
        chk("t3_ovf", out_ovf, 0);
        ack();

        // len=0: straight to a zero result
        send_cfg(8'd0);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_result", out_result, 0);
        ack();

        // Held result while a command is ignored; lane0 a=1..8 b=1 (36), lane1 a=2 b=-1 (-16)
        for (int e = 0; e < N; e++) begin
            in_a[e*W +: W]     = W'(e + 1);
            in_b[e*W +: W]     = 16'd1;
            in_a[(N+e)*W +: W] = 16'd2;
            in_b[(N+e)*W +: W] = 16'hFFFF;
        end
        send_cfg(8'd2);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        k = 1;
        wait_out("t5");
        for (int c = 0; c < 5; c++) begin
            cfg_valid = (c == 2);
            cfg_len   = 8'd1;
            tick();
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_result", out_result, 40);
            chk("t5_cfg_ready", cfg_ready, 0);
        end
        cfg_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_ack_idle", busy, 0);
        chk("t5_ack_cfg_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("t5_next_run", in_ready, 1);
        in_a = fill(16'd1);
        in_b = fill(16'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 1;
        wait_out("t5b");
        chk("t5_next_result", out_result, 32);
        ack();

        // Reset after 2 of 4 beats aborts the job
        send_cfg(8'd4);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cfg_ready", cfg_ready, 1);
        chk("t6_rst_tree_en", tree_en, 0);
        chk("t6_rst_result", out_result, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("t6_no_out", seen, 0);
        in_a = fill(16'hFFFD);
        in_b = fill(16'd5);
        send_cfg(8'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 1;
        wait_out("t6");
        chk("t6_after_result", out_result, -240);
        ack();

`ifdef VMAC_SEQ_CTRL_OVF_EN
        // One max-positive product per lane: 0x7FFE0002 per beat overflows a 32-bit acc on beat 2
        in_a = '0;
        in_b = '0;
        in_a[0 +: W]   = 16'h7FFF;
        in_b[0 +: W]   = 16'h7FFF;
        in_a[N*W +: W] = 16'h7FFF;
        in_b[N*W +: W] = 16'h7FFF;
        send_cfg(8'd2);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        k = 1;
        wait_out("ovf");
        chk("ovf_flag", out_ovf, 1);
        chk("ovf_result", out_result, 32'hFFFC0004);
        ack();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
